// File: rtl/decim_sampler.sv
// rtl/decim_sampler.sv - Sample decimator: emits the last sample (pick) or the sum (accumulate) of each N-sample window.
module decim_sampler #(
    parameter int WIDTH   = 8,
    parameter int RATIO_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic [RATIO_W-1:0]         ratio_i,
    input  logic                       mode_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       din_vld_i,
    output logic [WIDTH+RATIO_W-1:0]   dout_o,
    output logic                       dout_vld_o
);

    localparam int OW = WIDTH + RATIO_W;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t              state_q;
    logic [RATIO_W-1:0]  cnt_q;
    logic [RATIO_W-1:0]  nlat_q;
    logic                mode_q;
    logic [OW-1:0]       acc_q;
    logic [OW-1:0]       dout_q;
    logic                dout_vld_q;

    logic                accept_d;
    logic [RATIO_W-1:0]  neff_d;
    logic [OW-1:0]       din_ext_d;
    logic [OW-1:0]       sum_d;
    logic                last_d;

    // A window never holds more than 2^RATIO_W-1 samples, so OW bits cannot overflow.
    always_comb begin
        accept_d  = en_i & din_vld_i & ~clr_i;
        neff_d    = (ratio_i < RATIO_W'(2)) ? RATIO_W'(1) : ratio_i;
        din_ext_d = OW'(din_i);
        sum_d     = acc_q + din_ext_d;
        last_d    = (cnt_q == (nlat_q - RATIO_W'(1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nlat_q     <= RATIO_W'(1);
            mode_q     <= 1'b0;
            acc_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_vld_q <= 1'b0;
            if (clr_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                acc_q   <= '0;
            end else if (accept_d) begin
                case (state_q)
                    IDLE: begin
                        if (neff_d == RATIO_W'(1)) begin
                            dout_q     <= din_ext_d;
                            dout_vld_q <= 1'b1;
                        end else begin
                            state_q <= ACC;
                            cnt_q   <= RATIO_W'(1);
                            acc_q   <= din_ext_d;
                            nlat_q  <= neff_d;
                            mode_q  <= mode_i;
                        end
                    end
                    ACC: begin
                        if (last_d) begin
                            dout_q     <= mode_q ? sum_d : din_ext_d;
                            dout_vld_q <= 1'b1;
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            acc_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + RATIO_W'(1);
                            acc_q <= sum_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign dout_o     = dout_q;
    assign dout_vld_o = dout_vld_q;

endmodule
